hazard_scoreboard_unit: RTL and testbench
=========================================

Name: hazard_scoreboard_unit

Overview:
Parametrised successor to the combinational ID-stage hazard detector.
- Checks NUM_SRC source operands against the EXE and MEM stage destinations.
- Adds a load-use-only mode for pipelines that have forwarding.
- Adds a per-register countdown scoreboard for variable-latency producers, such as a multi-cycle multiplier.
- Adds a saturating stall performance counter.
- Sits beside the ID stage. Drives the freeze of PC/IF-ID and the bubble insert into ID-EXE.

Parameters:
- REG_ADDR_W, 5, register address width; the register file has 2**REG_ADDR_W entries.
- NUM_SRC, 2, number of source operands checked per instruction.
- MAX_LAT, 4, largest scoreboard latency in cycles; must be >= 1.
- FWD_EN, 0, 0 = stall on any EXE/MEM match; 1 = stall only on load-use.
- ZERO_REG_EN, 1, 1 = register 0 never causes a hazard.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- id_valid, in, 1, the ID stage holds a real instruction.
- id_src, in, NUM_SRC*REG_ADDR_W, source addresses; operand i is at bits [i*REG_ADDR_W +: REG_ADDR_W].
- id_src_check, in, NUM_SRC, per-operand enable.
- exe_dest, in, REG_ADDR_W, EXE stage destination register.
- exe_wb_en, in, 1, EXE stage will write back.
- exe_mem_read, in, 1, EXE stage instruction is a load.
- mem_dest, in, REG_ADDR_W, MEM stage destination register.
- mem_wb_en, in, 1, MEM stage will write back.
- issue_valid, in, 1, a long-latency op is being issued this cycle.
- issue_dest, in, REG_ADDR_W, destination of the long-latency op.
- issue_lat, in, clog2(MAX_LAT+1), latency of the long-latency op in cycles.
- hazard_detected, out, 1, combinational stall request.
- sb_busy, out, 1, at least one scoreboard entry is nonzero (registered state, combinational OR).
- stall_count, out, CNT_W, number of cycles in which hazard_detected was high; saturates.

Behaviour:
Reset and clocking
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: all scoreboard counters = 0, stall_count = 0. Therefore sb_busy = 0, and hazard_detected depends only on its combinational inputs.

Operand match (combinational)
- An operand i is "live" when id_valid = 1, id_src_check[i] = 1, and NOT (ZERO_REG_EN = 1 and src = 0).

Scoreboard
- One down-counter per register, each clog2(MAX_LAT+1) bits wide.
- Each cycle, every nonzero counter decrements by 1. A counter at 0 stays at 0.
- Issue with issue_valid = 1 and issue_lat != 0:
  - Let L = min(issue_lat, MAX_LAT).
  - The issue_dest counter loads max(L, its current value - 1). The issue takes priority over the same-cycle decrement.
- issue_lat = 0 is ignored.
- Issue to register 0 is ignored when ZERO_REG_EN = 1.
- A register is busy while its counter != 0.

Hazard equation (purely combinational from inputs and scoreboard state; 0 clock latency)
- hazard_detected = 1 when any live operand hits one of these:
  - Scoreboard busy for that register (in either FWD_EN mode).
  - FWD_EN = 0: (src == exe_dest and exe_wb_en) or (src == mem_dest and mem_wb_en).
  - FWD_EN = 1: src == exe_dest and exe_wb_en and exe_mem_read. MEM-stage matches never stall.
- id_valid = 0 forces hazard_detected = 0.

Stall counter
- Increments on every clk edge where hazard_detected = 1.
- Holds at 2**CNT_W - 1 once reached.

Boundary conditions
- Issue and ID read of the same register in the same cycle: no hazard that cycle, because the scoreboard is registered. The EXE match covers it when FWD_EN = 0.
- Reset asserted mid-countdown clears all counters immediately. sb_busy drops without waiting for a clock edge.

Test Plan:
1. FWD_EN=0, src1=3, exe_dest=3, exe_wb_en=1, id_valid=1 -> hazard_detected=1. With exe_wb_en=0 and mem_dest=3, mem_wb_en=1 -> 1. With src2_check=0 and only src2 matching -> 0.
2. FWD_EN=1: src1=4, exe_dest=4, exe_wb_en=1, exe_mem_read=0 -> 0. Set exe_mem_read=1 -> 1. mem_dest=4, mem_wb_en=1 alone -> 0.
3. ZERO_REG_EN=1: src1=0, exe_dest=0, exe_wb_en=1 -> 0. Issue to r0 with lat 3 -> sb_busy stays 0.
4. Scoreboard: issue r7, lat=3 at cycle 0; src1=7 held in ID -> hazard=1 in cycles 1, 2, 3 and 0 in cycle 4. Reissue r7 with lat=1 at cycle 1 -> counter stays at 2 (max rule).
5. issue_lat=7 with MAX_LAT=4 -> busy for exactly 4 cycles. Assert rst at cycle 2 -> sb_busy=0 and hazard=0 immediately; stall_count=0.
6. CNT_W=4, hold a hazard for 20 cycles -> stall_count reaches 15 and stays at 15.

Source files
------------

// File: rtl/hazard_scoreboard_unit_if.sv
// ID-stage hazard interface: operand/pipeline-destination inputs, long-latency issue
// and the stall/scoreboard status returned to the pipeline.
interface hazard_scoreboard_unit_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned MAX_LAT    = 4,
  parameter int unsigned CNT_W      = 16
);
  localparam int unsigned LAT_W = $clog2(MAX_LAT + 1);

  logic                          id_valid;
  logic [NUM_SRC*REG_ADDR_W-1:0] id_src;
  logic [NUM_SRC-1:0]            id_src_check;
  logic [REG_ADDR_W-1:0]         exe_dest;
  logic                          exe_wb_en;
  logic                          exe_mem_read;
  logic [REG_ADDR_W-1:0]         mem_dest;
  logic                          mem_wb_en;
  logic                          issue_valid;
  logic [REG_ADDR_W-1:0]         issue_dest;
  logic [LAT_W-1:0]              issue_lat;
  logic                          hazard_detected;
  logic                          sb_busy;
  logic [CNT_W-1:0]              stall_count;

  modport master (
    output id_valid, id_src, id_src_check, exe_dest, exe_wb_en, exe_mem_read,
           mem_dest, mem_wb_en, issue_valid, issue_dest, issue_lat,
    input  hazard_detected, sb_busy, stall_count
  );

  modport slave (
    input  id_valid, id_src, id_src_check, exe_dest, exe_wb_en, exe_mem_read,
           mem_dest, mem_wb_en, issue_valid, issue_dest, issue_lat,
    output hazard_detected, sb_busy, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard detector: EXE/MEM destination matching, per-register countdown
// scoreboard for long-latency producers, and a saturating stall counter.
module hazard_scoreboard_unit #(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned MAX_LAT     = 4,
  parameter bit          FWD_EN      = 1'b0,
  parameter bit          ZERO_REG_EN = 1'b1,
  parameter int unsigned CNT_W       = 16
) (
  input logic                    clk,
  input logic                    rst,
  hazard_scoreboard_unit_if.slave bus
);
  localparam int unsigned LAT_W   = $clog2(MAX_LAT + 1);
  localparam int unsigned NUM_REG = 2 ** REG_ADDR_W;
  localparam logic [LAT_W-1:0] MaxLat = LAT_W'(MAX_LAT);

  logic [LAT_W-1:0]      sb_q [NUM_REG];
  logic [LAT_W-1:0]      sb_d [NUM_REG];
  logic [NUM_REG-1:0]    busy_vec;
  logic [LAT_W-1:0]      issue_l;
  logic                  issue_ok;
  logic [REG_ADDR_W-1:0] src [NUM_SRC];
  logic [NUM_SRC-1:0]    op_hit;
  logic                  hazard;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  always_comb begin
    issue_l  = (bus.issue_lat > MaxLat) ? MaxLat : bus.issue_lat;
    issue_ok = bus.issue_valid && (bus.issue_lat != '0) &&
               !(ZERO_REG_EN && (bus.issue_dest == '0));
  end

  // A reissue never shortens an in-flight countdown: keep the larger of the two.
  always_comb begin
    for (int r = 0; r < NUM_REG; r++) begin
      busy_vec[r] = (sb_q[r] != '0);
      sb_d[r]     = busy_vec[r] ? sb_q[r] - 1'b1 : '0;
      if (issue_ok && (bus.issue_dest == REG_ADDR_W'(r)) && (issue_l > sb_d[r])) begin
        sb_d[r] = issue_l;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src[i]    = bus.id_src[i*REG_ADDR_W +: REG_ADDR_W];
      op_hit[i] = 1'b0;
      if (bus.id_valid && bus.id_src_check[i] && !(ZERO_REG_EN && (src[i] == '0))) begin
        op_hit[i] = busy_vec[src[i]] ||
                    (bus.exe_wb_en && (src[i] == bus.exe_dest) &&
                     (!FWD_EN || bus.exe_mem_read)) ||
                    (!FWD_EN && bus.mem_wb_en && (src[i] == bus.mem_dest));
      end
    end
    hazard = |op_hit;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (hazard && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_q  <= '{default: '0};
      cnt_q <= '0;
    end else begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.hazard_detected = hazard;
  assign bus.sb_busy         = |busy_vec;
  assign bus.stall_count     = cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: dut_a has FWD_EN=0/CNT_W=4, dut_b has FWD_EN=1/CNT_W=16,
// both driven with identical stimulus; expectations are queued per step and popped on sample.
module tb_hazard_scoreboard_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_unit_if #(.CNT_W(4))  bus_a ();
  hazard_scoreboard_unit_if #(.CNT_W(16)) bus_b ();

  hazard_scoreboard_unit #(.FWD_EN(1'b0), .CNT_W(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  hazard_scoreboard_unit #(.FWD_EN(1'b1), .CNT_W(16)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  typedef struct {
    string name;
    logic  a_hz;
    logic  b_hz;
    logic  busy;
    int    cnt_a;
    int    cnt_b;
  } exp_t;

  exp_t exp_q[$];

  task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [1:0] chk, input logic [4:0] ed, input logic ewb,
                       input logic erd, input logic [4:0] md, input logic mwb,
                       input logic iv, input logic [4:0] idst, input logic [2:0] il);
    bus_a.id_valid = v;     bus_b.id_valid = v;
    bus_a.id_src = {s1, s0}; bus_b.id_src = {s1, s0};
    bus_a.id_src_check = chk; bus_b.id_src_check = chk;
    bus_a.exe_dest = ed;    bus_b.exe_dest = ed;
    bus_a.exe_wb_en = ewb;  bus_b.exe_wb_en = ewb;
    bus_a.exe_mem_read = erd; bus_b.exe_mem_read = erd;
    bus_a.mem_dest = md;    bus_b.mem_dest = md;
    bus_a.mem_wb_en = mwb;  bus_b.mem_wb_en = mwb;
    bus_a.issue_valid = iv; bus_b.issue_valid = iv;
    bus_a.issue_dest = idst; bus_b.issue_dest = idst;
    bus_a.issue_lat = il;   bus_b.issue_lat = il;
  endtask

  task automatic push_exp(input string n, input logic ah, input logic bh, input logic bz,
                          input int ca = 0, input int cb = 0);
    exp_t e;
    e.name = n; e.a_hz = ah; e.b_hz = bh; e.busy = bz; e.cnt_a = ca; e.cnt_b = cb;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    push_exp("reset", 0, 0, 0, 0, 0);
    #3;
    e = exp_q.pop_front();
    n_checks++; if (bus_a.hazard_detected !== e.a_hz) begin n_fail++;
      $display("FAIL %s hazard_a got=%b want=%b", e.name, bus_a.hazard_detected, e.a_hz); end
    n_checks++; if (bus_a.sb_busy !== e.busy) begin n_fail++;
      $display("FAIL %s busy_a got=%b want=%b", e.name, bus_a.sb_busy, e.busy); end
    n_checks++; if (bus_a.stall_count !== 4'(e.cnt_a)) begin n_fail++;
      $display("FAIL %s cnt_a got=%0d want=%0d", e.name, bus_a.stall_count, e.cnt_a); end
    n_checks++; if (bus_b.stall_count !== 16'(e.cnt_b)) begin n_fail++;
      $display("FAIL %s cnt_b got=%0d want=%0d", e.name, bus_b.stall_count, e.cnt_b); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_match();
    exp_t e;
    for (int s = 0; s < 10; s++) begin
      case (s)
        0: begin drive(1, 3, 0, 2'b11, 3, 1, 0, 0, 0, 0, 0, 0); push_exp("exe_hit", 1, 0, 0); end
        1: begin drive(1, 3, 0, 2'b11, 3, 0, 0, 3, 1, 0, 0, 0); push_exp("mem_hit", 1, 0, 0); end
        2: begin drive(1, 5, 9, 2'b01, 9, 1, 0, 9, 1, 0, 0, 0); push_exp("src1_off", 0, 0, 0); end
        3: begin drive(1, 5, 9, 2'b11, 9, 1, 0, 9, 1, 0, 0, 0); push_exp("src1_on", 1, 0, 0); end
        4: begin drive(1, 4, 0, 2'b01, 4, 1, 0, 0, 0, 0, 0, 0); push_exp("no_load", 1, 0, 0); end
        5: begin drive(1, 4, 0, 2'b01, 4, 1, 1, 0, 0, 0, 0, 0); push_exp("load_use", 1, 1, 0); end
        6: begin drive(0, 4, 0, 2'b01, 4, 1, 1, 4, 1, 0, 0, 0); push_exp("invalid", 0, 0, 0); end
        7: begin drive(1, 4, 0, 2'b01, 0, 0, 0, 4, 1, 0, 0, 0); push_exp("mem_only", 1, 0, 0); end
        8: begin drive(1, 2, 4, 2'b10, 4, 1, 1, 0, 0, 0, 0, 0); push_exp("src1_load", 1, 1, 0); end
        default: begin drive(1, 2, 4, 2'b10, 4, 0, 1, 0, 0, 0, 0, 0); push_exp("no_wb", 0, 0, 0); end
      endcase
      #2;
      e = exp_q.pop_front();
      n_checks++; if (bus_a.hazard_detected !== e.a_hz) begin n_fail++;
        $display("FAIL %s hazard_a got=%b want=%b", e.name, bus_a.hazard_detected, e.a_hz); end
      n_checks++; if (bus_b.hazard_detected !== e.b_hz) begin n_fail++;
        $display("FAIL %s hazard_b got=%b want=%b", e.name, bus_b.hazard_detected, e.b_hz); end
      n_checks++; if (bus_a.sb_busy !== e.busy) begin n_fail++;
        $display("FAIL %s busy_a got=%b want=%b", e.name, bus_a.sb_busy, e.busy); end
      @(negedge clk);
    end
  endtask

  task automatic test_zero_reg();
    exp_t e;
    for (int s = 0; s < 4; s++) begin
      if (s == 0) drive(1, 0, 0, 2'b11, 0, 1, 1, 0, 1, 1, 0, 3);
      else        drive(1, 0, 0, 2'b11, 0, 1, 1, 0, 1, 0, 0, 0);
      push_exp($sformatf("zero_reg%0d", s), 0, 0, 0);
      #2;
      e = exp_q.pop_front();
      n_checks++; if (bus_a.hazard_detected !== e.a_hz) begin n_fail++;
        $display("FAIL %s hazard_a got=%b want=%b", e.name, bus_a.hazard_detected, e.a_hz); end
      n_checks++; if (bus_b.hazard_detected !== e.b_hz) begin n_fail++;
        $display("FAIL %s hazard_b got=%b want=%b", e.name, bus_b.hazard_detected, e.b_hz); end
      n_checks++; if (bus_a.sb_busy !== e.busy) begin n_fail++;
        $display("FAIL %s busy_a got=%b want=%b", e.name, bus_a.sb_busy, e.busy); end
      @(negedge clk);
    end
  endtask

  task automatic test_scoreboard();
    exp_t e;
    for (int s = 0; s < 9; s++) begin
      case (s)
        0: begin drive(1, 7, 0, 2'b01, 0, 0, 0, 0, 0, 1, 7, 3); push_exp("sb_issue", 0, 0, 0); end
        1: begin drive(1, 7, 0, 2'b01, 0, 0, 0, 0, 0, 1, 7, 1); push_exp("sb_c3", 1, 1, 1); end
        2: begin drive(1, 7, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0); push_exp("sb_c2", 1, 1, 1); end
        3: begin drive(1, 7, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0); push_exp("sb_c1", 1, 1, 1); end
        4: begin drive(1, 7, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0); push_exp("sb_c0", 0, 0, 0); end
        5: begin drive(1, 7, 0, 2'b01, 0, 0, 0, 0, 0, 1, 7, 2); push_exp("sb_re", 0, 0, 0); end
        6: begin drive(1, 8, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0); push_exp("sb_other", 0, 0, 1); end
        7: begin drive(1, 7, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0); push_exp("sb_r7", 1, 1, 1); end
        default: begin drive(1, 7, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0); push_exp("sb_done", 0, 0, 0); end
      endcase
      #2;
      e = exp_q.pop_front();
      n_checks++; if (bus_a.hazard_detected !== e.a_hz) begin n_fail++;
        $display("FAIL %s hazard_a got=%b want=%b", e.name, bus_a.hazard_detected, e.a_hz); end
      n_checks++; if (bus_b.hazard_detected !== e.b_hz) begin n_fail++;
        $display("FAIL %s hazard_b got=%b want=%b", e.name, bus_b.hazard_detected, e.b_hz); end
      n_checks++; if (bus_a.sb_busy !== e.busy) begin n_fail++;
        $display("FAIL %s busy_a got=%b want=%b", e.name, bus_a.sb_busy, e.busy); end
      n_checks++; if (bus_b.sb_busy !== e.busy) begin n_fail++;
        $display("FAIL %s busy_b got=%b want=%b", e.name, bus_b.sb_busy, e.busy); end
      @(negedge clk);
    end
  endtask

  task automatic test_latency_reset();
    exp_t e;
    for (int s = 0; s < 9; s++) begin
      case (s)
        0: begin drive(1, 10, 0, 2'b01, 0, 0, 0, 0, 0, 1, 10, 7); push_exp("lat_issue", 0, 0, 0); end
        1, 2, 3, 4: begin
          drive(1, 10, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0);
          push_exp($sformatf("lat_busy%0d", s), 1, 1, 1);
        end
        5: begin drive(1, 10, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0); push_exp("lat_clamp", 0, 0, 0); end
        6: begin drive(1, 10, 0, 2'b01, 0, 0, 0, 0, 0, 1, 10, 4); push_exp("rst_issue", 0, 0, 0); end
        7: begin drive(1, 10, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0); push_exp("rst_pre", 1, 1, 1); end
        default: begin
          drive(1, 10, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0);
          rst = 1'b1;
          push_exp("rst_async", 0, 0, 0);
        end
      endcase
      #2;
      e = exp_q.pop_front();
      n_checks++; if (bus_a.hazard_detected !== e.a_hz) begin n_fail++;
        $display("FAIL %s hazard_a got=%b want=%b", e.name, bus_a.hazard_detected, e.a_hz); end
      n_checks++; if (bus_b.hazard_detected !== e.b_hz) begin n_fail++;
        $display("FAIL %s hazard_b got=%b want=%b", e.name, bus_b.hazard_detected, e.b_hz); end
      n_checks++; if (bus_a.sb_busy !== e.busy) begin n_fail++;
        $display("FAIL %s busy_a got=%b want=%b", e.name, bus_a.sb_busy, e.busy); end
      n_checks++; if (bus_b.sb_busy !== e.busy) begin n_fail++;
        $display("FAIL %s busy_b got=%b want=%b", e.name, bus_b.sb_busy, e.busy); end
      if (s < 8) @(negedge clk);
    end
    n_checks++; if (bus_a.stall_count !== 4'd0) begin n_fail++;
      $display("FAIL rst_cnt_a got=%0d want=0", bus_a.stall_count); end
    n_checks++; if (bus_b.stall_count !== 16'd0) begin n_fail++;
      $display("FAIL rst_cnt_b got=%0d want=0", bus_b.stall_count); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_stall_sat();
    exp_t e;
    int   held;
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    for (int s = 0; s < 22; s++) begin
      // A load-use on r3 stalls both variants for 20 cycles, then ID goes idle.
      if (s < 20) drive(1, 3, 0, 2'b01, 3, 1, 1, 0, 0, 0, 0, 0);
      else        drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
      held = (s > 20) ? 20 : s;
      push_exp($sformatf("sat%0d", s), s < 20, s < 20, 0, (held > 15) ? 15 : held, held);
      #2;
      e = exp_q.pop_front();
      n_checks++; if (bus_a.hazard_detected !== e.a_hz) begin n_fail++;
        $display("FAIL %s hazard_a got=%b want=%b", e.name, bus_a.hazard_detected, e.a_hz); end
      n_checks++; if (bus_a.stall_count !== 4'(e.cnt_a)) begin n_fail++;
        $display("FAIL %s cnt_a got=%0d want=%0d", e.name, bus_a.stall_count, e.cnt_a); end
      n_checks++; if (bus_b.stall_count !== 16'(e.cnt_b)) begin n_fail++;
        $display("FAIL %s cnt_b got=%0d want=%0d", e.name, bus_b.stall_count, e.cnt_b); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_match();
    test_zero_reg();
    test_scoreboard();
    test_latency_reset();
    test_stall_sat();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
